// File: rtl/boot_rom_bridge_pkg.sv
// boot_rom_pkg: shared constants and the response record used by the boot
// ROM bridge and its response FIFO.
//   ROM_WORDS_DEF  number of populated ROM words
//   ROM_AW_DEF     ROM word-address width (ROM port A)
//   boot_rom_resp_t  one response: read data plus error flag
//   ERR_DATA       data returned with an error response
`timescale 1ns/1ps
package boot_rom_pkg;

    localparam int ROM_WORDS_DEF = 548;
    localparam int ROM_AW_DEF    = 10;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } boot_rom_resp_t;

    localparam logic [31:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/boot_rom_bridge_if.sv
// boot_rom_bridge_if: core-side request/response channel of the boot ROM
// bridge.
//   request : req_i, addr_i, we_i, be_i, wdata_i  (core -> bridge)
//             gnt_o                               (bridge -> core)
//   response: rvalid_o, rdata_o, err_o            (bridge -> core)
//             rready_i                            (core -> bridge)
// modport master is the core, modport slave is the bridge.
`timescale 1ns/1ps
interface boot_rom_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [3:0]            be_i;
    logic [31:0]           wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [31:0]           rdata_o;
    logic                  err_o;
    logic                  rready_i;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/boot_rom_bridge_resp_fifo.sv
// boot_rom_resp_fifo: 2-entry FIFO of boot_rom_resp_t. Storage only; the
// bridge decides when the pending entry bypasses the FIFO.
//   CLK, RSTN      clock, asynchronous active-low reset
//   push_i         write push_data_i at the tail (ignored when full unless
//                  a pop happens in the same cycle)
//   pop_i          drop the head (ignored when empty)
//   head_o         current head entry (meaningless when count_o == 0)
//   count_o        number of stored entries, 0..2
`timescale 1ns/1ps
module boot_rom_resp_fifo
    import boot_rom_pkg::*;
(
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           push_i,
    input  boot_rom_resp_t push_data_i,
    input  logic           pop_i,
    output boot_rom_resp_t head_o,
    output logic [1:0]     count_o
);

    boot_rom_resp_t mem_q [2];
    boot_rom_resp_t mem_d [2];
    logic           wr_q, wr_d;
    logic           rd_q, rd_d;
    logic [1:0]     count_q, count_d;
    logic           do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        do_pop  = pop_i & (count_q != 2'd0);
        do_push = push_i & ((count_q != 2'd2) | do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_data_i;
            wr_d        = ~wr_q;
        end
        if (do_pop) begin
            rd_d = ~rd_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/boot_rom_bridge.sv
// boot_rom_bridge: slave bridge from the core request channel to the boot ROM
// CSN/A/Q macro port. Word reads are forwarded to the ROM and answered one
// cycle later; writes and word indices >= ROM_WORDS get an error response with
// zero data. A pending stage plus a 2-entry FIFO hold responses while rready_i
// is low, so a granted read is never repeated on the ROM.
//   CLK, RSTN            clock, asynchronous active-low reset
//   bus (slave)          req/gnt request channel, rvalid/rready response
//   rom_csn_o            ROM chip select, active-low
//   rom_addr_o           ROM word address
//   rom_q_i              ROM data, valid the cycle after rom_csn_o was low
// Optional (macro BOOT_ROM_BRIDGE_PERF_EN):
//   perf_clr_i           clear both performance counters
//   perf_rd_o            saturating count of granted ROM reads
//   perf_err_o           saturating count of error responses
`timescale 1ns/1ps
module boot_rom_bridge
    import boot_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ROM_AW     = ROM_AW_DEF,
    parameter int ROM_WORDS  = ROM_WORDS_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    boot_rom_bridge_if.slave  bus,
    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [31:0]       rom_q_i
`ifdef BOOT_ROM_BRIDGE_PERF_EN
    ,
    input  logic              perf_clr_i,
    output logic [31:0]       perf_rd_o,
    output logic [15:0]       perf_err_o
`endif
);

    logic              p_valid_q, p_valid_d;
    logic              p_err_q, p_err_d;
    logic [ROM_AW-1:0] index;
    logic              in_range;
    logic              bad_req;
    logic              gnt;
    logic              rd_hit;
    logic [1:0]        count;
    logic              rvalid;
    logic              pop, fifo_pop, fifo_push;
    boot_rom_resp_t    pend, fifo_head, head;
    logic              unused_bits;

    assign index    = bus.addr_i[ROM_AW+1:2];
    assign in_range = ({1'b0, index} < (ROM_AW+1)'(ROM_WORDS));
    assign bad_req  = bus.we_i | ~in_range;

    // Grant depends on registered occupancy only, never on rready_i. RSTN
    // gates it so nothing is granted (and the ROM stays deselected) in reset.
    assign gnt    = RSTN & bus.req_i & (({1'b0, count} + {2'b00, p_valid_q}) < 3'd2);
    assign rd_hit = gnt & ~bad_req;

    assign bus.gnt_o  = gnt;
    assign rom_csn_o  = ~rd_hit;
    assign rom_addr_o = RSTN ? index : '0;

    always_comb begin
        pend.err  = p_err_q;
        pend.data = p_err_q ? ERR_DATA : rom_q_i;
    end

    assign rvalid = (count != 2'd0) | p_valid_q;
    assign head   = (count != 2'd0) ? fifo_head : pend;
    assign pop    = rvalid & bus.rready_i;

    // The pending entry goes into the FIFO unless it was consumed directly
    // through the bypass this cycle.
    assign fifo_pop  = pop & (count != 2'd0);
    assign fifo_push = p_valid_q & ~(pop & (count == 2'd0));

    boot_rom_resp_fifo u_fifo (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .push_i      (fifo_push),
        .push_data_i (pend),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (count)
    );

    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = rvalid ? head.data : '0;
    assign bus.err_o    = rvalid & head.err;

    always_comb begin
        p_valid_d = gnt;
        p_err_d   = gnt & bad_req;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            p_valid_q <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_err_q   <= p_err_d;
        end
    end

`ifdef BOOT_ROM_BRIDGE_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [15:0] perf_err_q, perf_err_d;

    always_comb begin
        perf_rd_d  = perf_rd_q;
        perf_err_d = perf_err_q;
        if (perf_clr_i) begin
            perf_rd_d  = '0;
            perf_err_d = '0;
        end else begin
            if (rd_hit && (perf_rd_q != '1)) begin
                perf_rd_d = perf_rd_q + 32'd1;
            end
            if (gnt && bad_req && (perf_err_q != '1)) begin
                perf_err_d = perf_err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            perf_rd_q  <= '0;
            perf_err_q <= '0;
        end else begin
            perf_rd_q  <= perf_rd_d;
            perf_err_q <= perf_err_d;
        end
    end

    assign perf_rd_o  = perf_rd_q;
    assign perf_err_o = perf_err_q;
`endif

    // be_i, wdata_i and the address bits outside the word index carry no
    // meaning for a read-only ROM.
    assign unused_bits = ^{bus.be_i, bus.wdata_i,
                           bus.addr_i[ADDR_WIDTH-1:ROM_AW+2], bus.addr_i[1:0]};

endmodule

// File: tb/tb_boot_rom_bridge.sv
// tb_boot_rom_bridge: self-checking bench for boot_rom_bridge. A behavioural
// ROM answers chip-selected reads one cycle later; a queue of outstanding
// responses predicts grant, ROM access and response data. Build with
// BOOT_ROM_BRIDGE_PERF_EN defined to also check the performance counters.
`timescale 1ns/1ps
module tb_boot_rom_bridge;
    import boot_rom_pkg::*;

    localparam int NWORDS = 548;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        rom_csn;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q;
    logic [31:0] mem [1024];

    always #5 CLK = ~CLK;

    boot_rom_bridge_if #(.ADDR_WIDTH(32)) bus ();

`ifdef BOOT_ROM_BRIDGE_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_rd;
    logic [15:0] perf_err;
`endif

    boot_rom_bridge dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .bus        (bus),
        .rom_csn_o  (rom_csn),
        .rom_addr_o (rom_addr),
        .rom_q_i    (rom_q)
`ifdef BOOT_ROM_BRIDGE_PERF_EN
        ,
        .perf_clr_i (perf_clr),
        .perf_rd_o  (perf_rd),
        .perf_err_o (perf_err)
`endif
    );

    // Behavioural ROM: data for a selected word appears the next cycle,
    // otherwise the output is noise.
    always @(posedge CLK) begin
        if (!rom_csn) rom_q <= mem[rom_addr];
        else          rom_q <= $urandom;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_mis = 0;
    int          exp_rd = 0;
    int          exp_er = 0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_we = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs, check everything against the model, then
    // advance the model across the clock edge.
    task automatic step(input logic req, input logic [31:0] addr, input logic we,
                        input logic rdy, output logic g);
        logic [9:0] idx;
        logic       bad;
        logic       e_gnt;
        logic       e_rv;
        exp_t       e;
        @(negedge CLK);
        bus.req_i    = req;
        bus.addr_i   = addr;
        bus.we_i     = we;
        bus.be_i     = 4'($urandom);
        bus.wdata_i  = $urandom;
        bus.rready_i = rdy;
        assert (!(prev_req && !prev_gnt) || (req && addr == prev_addr && we == prev_we))
            else $error("requester changed a request before it was granted");
        #1;
        idx   = addr[11:2];
        bad   = we || (int'(idx) >= NWORDS);
        e_gnt = req && (q.size() < 2);
        e_rv  = (q.size() != 0);
        check_val("gnt", 32'(bus.gnt_o), 32'(e_gnt));
        check_val("rom_csn", 32'(rom_csn), 32'(!(e_gnt && !bad)));
        check_val("rom_addr", 32'(rom_addr), 32'(idx));
        check_val("rvalid", 32'(bus.rvalid_o), 32'(e_rv));
        if (e_rv) begin
            check_val("rdata", bus.rdata_o, q[0].data);
            check_val("err", 32'(bus.err_o), 32'(q[0].err));
        end
        @(posedge CLK);
        if (e_rv && rdy) void'(q.pop_front());
        if (e_gnt) begin
            e.err  = bad;
            e.data = bad ? 32'h0 : mem[idx];
            q.push_back(e);
            if (bad) exp_er++;
            else     exp_rd++;
        end
        prev_req  = req;
        prev_gnt  = e_gnt;
        prev_addr = addr;
        prev_we   = we;
        g = e_gnt;
    endtask

    // Issue one request and hold it until granted, bounded.
    task automatic issue(input logic [31:0] addr, input logic we, input logic rdy);
        logic g;
        int   n;
        g = 1'b0;
        n = 0;
        while (!g && n < 10) begin
            step(1'b1, addr, we, rdy, g);
            n++;
        end
        if (!g) begin
            n_vec++;
            n_mis++;
            $display("FAIL issue_timeout: got no grant, want grant within 10 cycles");
        end
    endtask

    task automatic drain();
        logic g;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, g);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_gnt", 32'(bus.gnt_o), 32'h0);
        check_val("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        check_val("rst_rdata", bus.rdata_o, 32'h0);
        check_val("rst_err", 32'(bus.err_o), 32'h0);
        check_val("rst_csn", 32'(rom_csn), 32'h1);
        check_val("rst_rom_addr", 32'(rom_addr), 32'h0);
    endtask

    task automatic model_reset();
        q.delete();
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        exp_rd   = 0;
        exp_er   = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g;
        logic        h_req;
        logic [31:0] h_addr;
        logic        h_we;
        logic        rdy;
        int          idx;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_0013;
        mem[36] = 32'h0000_0093;
        mem[31] = 32'h0100_006F;

        // Reset with a request already asserted: nothing may be granted.
        RSTN         = 1'b0;
        bus.req_i    = 1'b1;
        bus.addr_i   = 32'h7C;
        bus.we_i     = 1'b0;
        bus.be_i     = 4'hF;
        bus.wdata_i  = 32'h0;
        bus.rready_i = 1'b1;
`ifdef BOOT_ROM_BRIDGE_PERF_EN
        perf_clr = 1'b0;
`endif
        #1;
        check_reset_outputs();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        bus.req_i = 1'b0;
        RSTN      = 1'b1;

        // Single read of word 31, then back-to-back reads of 0, 36, 31.
        issue(32'h7C, 1'b0, 1'b1);
        drain();
        issue(32'h00, 1'b0, 1'b1);
        issue(32'h90, 1'b0, 1'b1);
        issue(32'h7C, 1'b0, 1'b1);
        drain();

        // Back-pressure: two grants, the rest stall with the ROM idle.
        for (int i = 0; i < 2; i++) step(1'b1, 32'(16 + 4 * i), 1'b0, 1'b0, g);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h18, 1'b0, 1'b0, g);
        issue(32'h18, 1'b0, 1'b1);
        issue(32'h1C, 1'b0, 1'b1);
        drain();

        // Write and out-of-range read produce error responses.
        issue(32'h14, 1'b1, 1'b1);
        issue(32'(600 * 4), 1'b0, 1'b1);
        issue(32'(548 * 4), 1'b0, 1'b0);
        issue(32'(547 * 4), 1'b0, 1'b1);
        drain();

        // Reset with the buffer full drops everything.
        step(1'b1, 32'h40, 1'b0, 1'b0, g);
        step(1'b1, 32'h44, 1'b0, 1'b0, g);
        step(1'b0, 32'h0, 1'b0, 1'b0, g);
        @(negedge CLK);
        bus.req_i = 1'b0;
        RSTN      = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1, g);
        issue(32'h7C, 1'b0, 1'b1);
        drain();

`ifdef BOOT_ROM_BRIDGE_PERF_EN
        check_val("perf_rd_after_reset", perf_rd, 32'd1);
        @(negedge CLK);
        perf_clr = 1'b1;
        @(negedge CLK);
        perf_clr = 1'b0;
        model_reset();
        issue(32'h00, 1'b0, 1'b1);
        issue(32'h04, 1'b1, 1'b1);
        issue(32'h08, 1'b0, 1'b1);
        issue(32'(700 * 4), 1'b0, 1'b1);
        issue(32'h0C, 1'b0, 1'b1);
        drain();
        check_val("perf_rd", perf_rd, 32'd3);
        check_val("perf_err", 32'(perf_err), 32'd2);
        @(negedge CLK);
        perf_clr = 1'b1;
        @(negedge CLK);
        perf_clr = 1'b0;
        #1;
        check_val("perf_rd_clr", perf_rd, 32'd0);
        check_val("perf_err_clr", 32'(perf_err), 32'd0);
        model_reset();
`endif

        // Random traffic with random back-pressure.
        h_req  = 1'b0;
        h_addr = '0;
        h_we   = 1'b0;
        g      = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(h_req && !g)) begin
                h_req  = ($urandom_range(0, 3) != 0);
                idx    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(548, 1023))
                                                     : int'($urandom_range(0, 547));
                h_addr = $urandom;
                h_addr[11:2] = 10'(idx);
                h_we   = ($urandom_range(0, 7) == 0);
            end
            rdy = ($urandom_range(0, 2) != 0);
            step(h_req, h_addr, h_we, rdy, g);
        end
        drain();
        check_val("final_empty", 32'(bus.rvalid_o), 32'h0);
`ifdef BOOT_ROM_BRIDGE_PERF_EN
        check_val("perf_rd_random", perf_rd, 32'(exp_rd));
        check_val("perf_err_random", 32'(perf_err), 32'(exp_er));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/boot_rom_bridge.md
Name: boot_rom_bridge

Overview:
- Slave-side bridge between the core's instruction/data request channel (req/gnt, then rvalid) and the boot ROM macro's CSN/A/Q port.
- Accepts word reads, drives the ROM chip-select and word address, and returns ROM data with one cycle of latency.
- Writes and out-of-range word indices get an error response.
- A 2-entry response buffer absorbs rready back-pressure so the ROM is never re-read.

Parameters:
- ADDR_WIDTH, 32, byte-address width of addr_i
- ROM_AW, 10, ROM word-address width (matches ROM port A)
- ROM_WORDS, 548, number of valid ROM words; word index >= ROM_WORDS is out of range

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid
- addr_i  in  ADDR_WIDTH  byte address; bits [ROM_AW+1:2] are the word index, other bits ignored
- we_i  in  1  write enable (always an error)
- be_i  in  4  byte enables (ignored)
- wdata_i  in  32  write data (ignored)
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid
- rdata_o  out  32  response data
- err_o  out  1  response error flag, qualified by rvalid_o
- rready_i  in  1  consumer accepts response
- rom_csn_o  out  1  ROM chip select, active-low
- rom_addr_o  out  ROM_AW  ROM word address
- rom_q_i  in  32  ROM data, valid the cycle after rom_csn_o is low

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, rom_csn_o=1, rom_addr_o=0. Buffer and pending stage are cleared.
- State elements:
  - Pending stage p_valid/p_err: the request accepted last cycle.
  - 2-entry FIFO of {data[31:0], err}, with count 0..2.
- Grant:
  - gnt_o = req_i & (count + p_valid < 2).
  - Combinational from req_i and registered state only; never depends on rready_i.
- Access:
  - On a grant with ~we_i and index < ROM_WORDS: rom_csn_o=0 and rom_addr_o=index (combinational), p_valid<=1, p_err<=0.
  - On a grant with a write or an out-of-range index: rom_csn_o stays 1, p_valid<=1, p_err<=1.
  - With no grant: p_valid<=0, rom_csn_o=1, and rom_addr_o holds the index of addr_i with no functional meaning.
- Response entry: pending entry data = p_err ? 32'h0 : rom_q_i. rom_q_i is sampled only while p_valid=1.
- Output selection:
  - rvalid_o = (count!=0) | p_valid.
  - The head is FIFO[rd] when count!=0, otherwise the pending entry (bypass).
  - Latency grant→rvalid is 1 cycle with an empty buffer.
- Push/pop:
  - Pop when rvalid_o & rready_i.
  - The pending entry is pushed into the FIFO unless it was the head and was popped this cycle.
  - Simultaneous push and pop keep count unchanged.
  - Order is strictly preserved.
- Full: count + p_valid = 2 forces gnt_o=0. A req_i held high keeps its addr_i/we_i stable until granted (requester rule, asserted in the bench).
- Throughput: with rready_i=1 continuously, one grant every cycle.
- Reset mid-operation drops pending and buffered responses; no rvalid_o after RSTN deasserts until a new grant.

Optional Feature:
- Macro BOOT_ROM_BRIDGE_PERF_EN.
- Defined:
  - Adds ports perf_clr_i (in, 1), perf_rd_o (out, 32) and perf_err_o (out, 16).
  - Saturating counters of granted ROM reads and error responses; reset 0.
  - perf_clr_i zeroes both counters next cycle; clear wins over a same-cycle increment.
- Undefined: these ports and the counters do not exist.

Decomposition:
- Package boot_rom_pkg:
  - constants ROM_WORDS_DEF=548 and ROM_AW_DEF=10
  - typedef boot_rom_resp_t {logic [31:0] data; logic err;}
  - ERR_DATA=32'h0
- Sub-module boot_rom_resp_fifo: 2-entry FIFO of boot_rom_resp_t with push/pop/count, head output and bypass-free storage. The bridge does the bypass muxing.

Test Plan:
- Read addr 0x7C (word 31), rready=1 → rom_csn_o=0 and rom_addr_o=31 in the grant cycle; next cycle rvalid=1, rdata=0x0100006F, err=0.
- Back-to-back reads of words 0, 36, 31 with rready=1 → three consecutive grants; rdata 0x00000013, 0x00000093, 0x0100006F on consecutive cycles.
- rready=0 with four reads issued → two grants, then gnt_o=0. Raising rready drains in order, with no extra ROM accesses (rom_csn_o=1 while stalled).
- Write to word 5, and read of word 600 → rom_csn_o stays 1; responses have err=1 and rdata=0.
- Reset asserted with count=2 → rvalid_o=0 immediately, count=0; first grant after release behaves as in the first scenario.
- With BOOT_ROM_BRIDGE_PERF_EN: 3 reads and 2 errors → perf_rd_o=3, perf_err_o=2; pulse perf_clr_i → both 0.
